// File: rtl/frame_scheduler.sv
// Frame capture sequencer: arms the sensor, tracks rows through a
// two-entry index buffer, counts frames and watches for stalls.
module frame_scheduler #(
  parameter int ROWS      = 2,
  parameter int TIMEOUT   = 1023,
  parameter int FCNT_BITS = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CAPTURE_REQ,
  input  logic CONTINUOUS,
  input  logic ABORT,
  input  logic SENSOR_NEW_ROW,
  input  logic SENSOR_FRAME_FINISHED,
  output logic SENSOR_RESET,
  output logic ROW_VALID,
  input  logic ROW_READY,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] ROW_INDEX,
  output logic BUSY,
  output logic FRAME_DONE,
  output logic [FCNT_BITS-1:0] FRAME_COUNT,
  output logic OVERRUN,
  output logic ROW_MISMATCH,
  output logic ERROR
);

  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(ROWS + 1);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE,
    S_FAULT
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] row_cnt, row_nxt;
  logic [WW-1:0] wdog;
  logic [IW-1:0] ent0, ent1, push_val;
  logic [1:0]    fcnt;
  logic          push, pop, flush;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (CAPTURE_REQ || CONTINUOUS) state_nxt = S_ARM;
      S_ARM:
        state_nxt = ABORT ? S_IDLE : S_RUN;
      S_RUN:
        if (ABORT) state_nxt = S_IDLE;
        else if (SENSOR_FRAME_FINISHED) state_nxt = S_DONE;
        else if (wdog == WW'(TIMEOUT)) state_nxt = S_FAULT;
      S_DONE:
        if (ABORT) state_nxt = S_IDLE;
        else state_nxt = CONTINUOUS ? S_ARM : S_IDLE;
      S_FAULT:
        if (ABORT) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // Row counter sticks at ROWS so a runaway sensor cannot wrap it
  always_comb begin
    row_nxt = row_cnt;
    if (SENSOR_NEW_ROW && row_cnt != CW'(ROWS))
      row_nxt = row_cnt + CW'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= S_IDLE;
      SENSOR_RESET <= 1'b1;
      BUSY         <= 1'b0;
      FRAME_DONE   <= 1'b0;
      ERROR        <= 1'b0;
      FRAME_COUNT  <= '0;
      ROW_MISMATCH <= 1'b0;
      row_cnt      <= '0;
      wdog         <= '0;
    end else begin
      state        <= state_nxt;
      SENSOR_RESET <= (state_nxt != S_RUN);
      BUSY         <= (state_nxt != S_IDLE);
      FRAME_DONE   <= (state_nxt == S_DONE);
      ERROR        <= (state_nxt == S_FAULT);
      if (state == S_ARM) begin
        row_cnt      <= '0;
        wdog         <= '0;
        ROW_MISMATCH <= 1'b0;
      end
      if (state == S_RUN) begin
        wdog    <= wdog + WW'(1);
        row_cnt <= row_nxt;
        if (state_nxt == S_DONE) begin
          FRAME_COUNT <= FRAME_COUNT + FCNT_BITS'(1);
          if (row_nxt != CW'(ROWS))
            ROW_MISMATCH <= 1'b1;
        end
      end
    end
  end

  assign push     = (state == S_RUN) && SENSOR_NEW_ROW;
  assign pop      = (fcnt != 2'd0) && ROW_READY;
  assign flush    = (state == S_ARM) || ABORT;
  assign push_val = IW'(row_cnt);

  // ent0 is always the head; ent1 only holds data when fcnt == 2
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fcnt    <= 2'd0;
      ent0    <= '0;
      ent1    <= '0;
      OVERRUN <= 1'b0;
    end else begin
      if (state == S_ARM)
        OVERRUN <= 1'b0;
      if (flush) begin
        fcnt <= 2'd0;
      end else begin
        unique case ({push, pop})
          2'b01: begin
            ent0 <= ent1;
            fcnt <= fcnt - 2'd1;
          end
          2'b10: begin
            if (fcnt == 2'd0) begin
              ent0 <= push_val;
              fcnt <= 2'd1;
            end else if (fcnt == 2'd1) begin
              ent1 <= push_val;
              fcnt <= 2'd2;
            end else begin
              OVERRUN <= 1'b1;
            end
          end
          2'b11: begin
            if (fcnt == 2'd1) begin
              ent0 <= push_val;
            end else begin
              ent0 <= ent1;
              ent1 <= push_val;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ROW_VALID = (fcnt != 2'd0);
  assign ROW_INDEX = ent0;

endmodule
